// File: rtl/mult_unit_pkg.sv
// mult_unit_pkg: funct3 and FSM encodings shared by the multiplier, ACU and ALU.
package mult_unit_pkg;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mult_abs.sv
// mult_abs: magnitude and sign of an operand; the most-negative value maps onto its unsigned magnitude.
module mult_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         is_signed,
    output logic [W-1:0] mag,
    output logic         neg
);
    assign neg = is_signed & val[W-1];
    assign mag = neg ? -val : val;
endmodule

// File: rtl/mult_unit.sv
// mult_unit: iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
module mult_unit
    import mult_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  MULT_CLOCK_50,
    input  logic                  MULT_RESET_InHigh,
    input  logic                  MULT_Start_In,
    input  logic                  MULT_Abort_In,
    input  logic [2:0]            MULT_Funt3_InBUS,
    input  logic [DATA_WIDTH-1:0] MULT_DataA_InBUS,
    input  logic [DATA_WIDTH-1:0] MULT_DataB_InBUS,
    output logic                  MULT_Busy_Out,
    output logic                  MULT_Done_Out,
    output logic [DATA_WIDTH-1:0] MULT_Result_OutBUS
);
    localparam int W = DATA_WIDTH;
    state_t state, state_nx;
    logic [2:0] f3;
    logic [4:0] cnt;
    logic sgn, fin, a_signed, b_signed, neg_a, neg_b, hi_sel;
    logic [W-1:0] mcand, mag_a, mag_b;
    logic [2*W-1:0] acc, prod;
    logic [W:0] sum;
    assign a_signed = MULT_Funt3_InBUS != F3_MULHU;
    assign b_signed = a_signed && MULT_Funt3_InBUS != F3_MULHSU;
    mult_abs #(.W(W)) u_abs_a (.val(MULT_DataA_InBUS), .is_signed(a_signed), .mag(mag_a), .neg(neg_a));
    mult_abs #(.W(W)) u_abs_b (.val(MULT_DataB_InBUS), .is_signed(b_signed), .mag(mag_b), .neg(neg_b));
    always_comb begin
        state_nx = MULT_Abort_In ? ST_IDLE :
                   state == ST_IDLE ? (MULT_Start_In ? ST_CALC : ST_IDLE) :
                   state == ST_CALC ? (fin ? ST_DONE : ST_CALC) : ST_IDLE;
        sum = {1'b0, acc[2*W-1:W]} + {1'b0, mcand};
        prod = sgn ? -acc : acc;
        hi_sel = f3 inside {F3_MULH, F3_MULHSU, F3_MULHU};
    end
    assign MULT_Busy_Out = state == ST_CALC;
    assign MULT_Done_Out = state == ST_DONE;
    // fin marks that all W steps are in, so the next CALC edge only does the fix-up
    always_ff @(posedge MULT_CLOCK_50 or posedge MULT_RESET_InHigh) begin
        if (MULT_RESET_InHigh) begin
            state <= ST_IDLE;
            f3 <= '0;
            cnt <= '0;
            sgn <= 1'b0;
            fin <= 1'b0;
            mcand <= '0;
            acc <= '0;
            MULT_Result_OutBUS <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && MULT_Start_In && !MULT_Abort_In) begin
                f3 <= MULT_Funt3_InBUS;
                mcand <= mag_a;
                acc <= {{W{1'b0}}, mag_b};
                sgn <= neg_a ^ neg_b;
                cnt <= '0;
                fin <= 1'b0;
            end else if (state == ST_CALC && !MULT_Abort_In) begin
                if (fin)
                    MULT_Result_OutBUS <= hi_sel ? prod[2*W-1:W] : prod[W-1:0];
                else begin
                    acc <= acc[0] ? {sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
                    cnt <= cnt + 5'd1;
                    fin <= cnt == 5'(W-1);
                end
            end
        end
    end
endmodule
